// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light controller's 6-bit lights bus.
// Decodes each sampled pattern into a phase and checks phase order and
// per-phase dwell time against the controller's timing contract. It counts
// completed light cycles and latches sticky error flags until rearm.
//
// Interface timing: there is no valid/ready handshake. lights is sampled on
// every rising edge, and every output is updated on the edge that samples the
// pattern causing the change. rearm is a one-cycle pulse that only has an
// effect in FAULT. The FSM state is visible through synced (TRACK) and
// fault (FAULT); when both are low the monitor is in SYNC.
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 5,
  parameter int YELLOW_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] lights,
  input  logic       rearm,
  output logic [1:0] phase,
  output logic       synced,
  output logic       fault,
  output logic       err_illegal,
  output logic       err_order,
  output logic       err_dwell,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [5:0] PAT_S0 = 6'b001100;
  localparam logic [5:0] PAT_S1 = 6'b010100;
  localparam logic [5:0] PAT_S2 = 6'b100001;
  localparam logic [5:0] PAT_S3 = 6'b100010;

  localparam logic [CNT_W-1:0] DWELL_GREEN  = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] DWELL_YELLOW = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             partial_q, partial_d;
  logic             ill_q, ill_d;
  logic             ord_q, ord_d;
  logic             dwl_q, dwl_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             pat_legal;
  logic [1:0]       pat_phase;
  logic [CNT_W-1:0] dwell_exp;

  // Decode the sampled lights into a legal flag and a phase number.
  always_comb begin
    pat_legal = 1'b1;
    pat_phase = 2'd0;
    case (lights)
      PAT_S0:  pat_phase = 2'd0;
      PAT_S1:  pat_phase = 2'd1;
      PAT_S2:  pat_phase = 2'd2;
      PAT_S3:  pat_phase = 2'd3;
      default: pat_legal = 1'b0;
    endcase
  end

  // Odd phases are yellow, even phases are green.
  assign dwell_exp = phase_q[0] ? DWELL_YELLOW : DWELL_GREEN;

  // State register and tracking registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_SYNC;
      phase_q   <= 2'd0;
      dwell_q   <= '0;
      partial_q <= 1'b0;
      ill_q     <= 1'b0;
      ord_q     <= 1'b0;
      dwl_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      partial_q <= partial_d;
      ill_q     <= ill_d;
      ord_q     <= ord_d;
      dwl_q     <= dwl_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: sync on a legal pattern, then check order and dwell.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    partial_d = partial_q;
    ill_d     = ill_q;
    ord_d     = ord_q;
    dwl_d     = dwl_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_SYNC: begin
        if (pat_legal) begin
          state_d   = ST_TRACK;
          phase_d   = pat_phase;
          dwell_d   = DWELL_ONE;
          partial_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (pat_legal && (pat_phase == phase_q)) begin
          // Same phase held: overstay is only judged once a full phase
          // has been observed from its start.
          if (!partial_q && (dwell_q == dwell_exp)) begin
            dwl_d   = 1'b1;
            state_d = ST_FAULT;
          end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + DWELL_ONE;
          end
        end else if (!pat_legal) begin
          ill_d   = 1'b1;
          state_d = ST_FAULT;
        end else if (pat_phase != (phase_q + 2'd1)) begin
          ord_d   = 1'b1;
          state_d = ST_FAULT;
        end else if (!partial_q && (dwell_q < dwell_exp)) begin
          dwl_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          phase_d   = pat_phase;
          dwell_d   = DWELL_ONE;
          partial_d = 1'b0;
          if (pat_phase == 2'd0) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (rearm) begin
          ill_d   = 1'b0;
          ord_d   = 1'b0;
          dwl_d   = 1'b0;
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign phase       = phase_q;
  assign synced      = (state_q == ST_TRACK);
  assign fault       = (state_q == ST_FAULT);
  assign err_illegal = ill_q;
  assign err_order   = ord_q;
  assign err_dwell   = dwl_q;
  assign cycle_cnt   = cnt_q;

endmodule
